bpred_pht_update_sched: RTL and testbench

Sequences all writes into the 2-bit branch pattern history table (PHT) that sits behind the correlating/tournament dynamic predictor. Branch outcomes resolved in ID are buffered in a small queue. Each one is applied as a read-modify-write (saturating counter update) on the PHT's shared read port, with IF-stage prediction lookups always taking priority. After reset, the block also sweeps every PHT entry to a weakly-not-taken value.

---
 rtl/bpred_pkg.sv | 13 +
 rtl/bpred_res_fifo.sv | 32 +++
 rtl/bpred_pht_update_sched.sv | 72 +++++++
 tb/tb_bpred_pht_update_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared types and counter arithmetic for the PHT update scheduler
package bpred_pkg;
  localparam int IDX_MAX_W = 16;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD} state_e;
  typedef logic [1:0] ctr_t;
  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 taken;
  } res_entry_t;
  function automatic ctr_t sat_update(ctr_t ctr, logic taken);
    return taken ? ((ctr == 2'b11) ? ctr : ctr + 2'b01) : ((ctr == 2'b00) ? ctr : ctr - 2'b01);
  endfunction
endpackage

// File: rtl/bpred_res_fifo.sv
// bpred_res_fifo: synchronous FIFO (push/pop/full/empty); callers must not push when full without a pop
module bpred_res_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/bpred_pht_update_sched.sv
// bpred_pht_update_sched: PHT init sweep plus queued read-modify-write counter updates behind IF lookups
module bpred_pht_update_sched
  import bpred_pkg::*;
#(
  parameter int   IDX_W    = 5,
  parameter int   DEPTH    = 4,
  parameter ctr_t INIT_VAL = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  input  logic             lookup_valid,
  output logic             pht_rd_en,
  output logic [IDX_W-1:0] pht_rd_idx,
  input  logic [1:0]       pht_rd_data,
  output logic             pht_wr_en,
  output logic [IDX_W-1:0] pht_wr_idx,
  output logic [1:0]       pht_wr_data,
  output logic             upd_full,
  output logic             init_done,
  output logic [7:0]       drop_cnt
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] sweep_q, head_idx;
  logic init_done_q;
  logic [7:0] drop_q;
  res_entry_t push_entry, head;
  logic push, pop, drop, full, empty;
  assign push_entry = '{idx: IDX_MAX_W'(res_idx), taken: res_taken};
  assign head_idx   = IDX_W'(head.idx);
  assign pop        = state_q == ST_RD;
  // a full queue still accepts when its head leaves in the same cycle
  assign push       = res_valid && (!full || pop);
  assign drop       = res_valid && full && !pop;
  bpred_res_fifo #(.WIDTH($bits(res_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // rst gates the RD write so an in-flight update is abandoned
  always_comb begin
    pht_rd_en   = !rst && state_q == ST_IDLE && !empty && !lookup_valid;
    pht_rd_idx  = head_idx;
    pht_wr_en   = state_q == ST_INIT || (state_q == ST_RD && !rst);
    pht_wr_idx  = (state_q == ST_INIT) ? sweep_q : head_idx;
    pht_wr_data = (state_q == ST_INIT) ? INIT_VAL : sat_update(pht_rd_data, head.taken);
    state_d     = (state_q == ST_INIT) ? (&sweep_q ? ST_IDLE : ST_INIT) : pht_rd_en ? ST_RD : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) sweep_q <= sweep_q + IDX_W'(1);
      if (state_q == ST_INIT && &sweep_q) init_done_q <= 1'b1;
      if (drop && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
    end
  end
  assign upd_full  = full;
  assign init_done = init_done_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_bpred_pht_update_sched.sv
// tb_bpred_pht_update_sched: scoreboard bench with a PHT model for bpred_pht_update_sched
module tb_bpred_pht_update_sched;
  localparam int IDX_W = 5;
  typedef struct packed {
    logic [4:0] idx;
    logic [1:0] data;
  } wr_t;
  logic clk = 1'b0, rst = 1'b1, res_valid = 1'b0, res_taken = 1'b0, lookup_valid = 1'b0;
  logic [IDX_W-1:0] res_idx = '0;
  logic pht_rd_en, pht_wr_en, upd_full, init_done;
  logic [IDX_W-1:0] pht_rd_idx, pht_wr_idx;
  logic [1:0] pht_wr_data;
  logic [1:0] pht_rd_data = 2'b00;
  logic [7:0] drop_cnt;
  logic [1:0] pht [32];
  wr_t exp_q[$];
  int wr_cyc_q[$];
  int cyc = 0, tests = 0, fails = 0;
  bpred_pht_update_sched #(.IDX_W(IDX_W), .DEPTH(4), .INIT_VAL(2'b01)) dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid    (res_valid),
    .res_idx      (res_idx),
    .res_taken    (res_taken),
    .lookup_valid (lookup_valid),
    .pht_rd_en    (pht_rd_en),
    .pht_rd_idx   (pht_rd_idx),
    .pht_rd_data  (pht_rd_data),
    .pht_wr_en    (pht_wr_en),
    .pht_wr_idx   (pht_wr_idx),
    .pht_wr_data  (pht_wr_data),
    .upd_full     (upd_full),
    .init_done    (init_done),
    .drop_cnt     (drop_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pht_wr_en) pht[pht_wr_idx] <= pht_wr_data;
    if (pht_rd_en) pht_rd_data <= pht[pht_rd_idx];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!rst && pht_wr_en) begin
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: idx %0d data %0d, expected no write", pht_wr_idx, pht_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_idx", 32'(pht_wr_idx), 32'(e.idx));
        chk("wr_data", 32'(pht_wr_data), 32'(e.data));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask
  function automatic void exp_wr(input int idx, input logic [1:0] d);
    exp_q.push_back('{idx: 5'(idx), data: d});
  endfunction
  function automatic void exp_sweep();
    for (int i = 0; i < 32; i++) exp_wr(i, 2'b01);
  endfunction
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      cyc1();
      n++;
    end
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc1();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    cyc1();
    cyc1();
  endtask
  initial begin
    int n;
    wr_t pushes [7];
    // reset state and init sweep
    cyc1();
    cyc1();
    cyc1();
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_upd_full", 32'(upd_full), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_rd_en", 32'(pht_rd_en), 32'd0);
    exp_sweep();
    rst = 1'b0;
    chk("first_wr_en", 32'(pht_wr_en), 32'd1);
    chk("first_wr_idx", 32'(pht_wr_idx), 32'd0);
    chk("first_wr_data", 32'(pht_wr_data), 32'd1);
    wait_init(n);
    chk("init_cycles", 32'(n), 32'd32);
    chk("sweep_writes_left", 32'(exp_q.size()), 32'd0);
    cyc1();
    cyc1();
    // idx 3 taken three times: 01 -> 10 -> 11 -> 11, writes two cycles apart
    wr_cyc_q.delete();
    exp_wr(3, 2'b10);
    exp_wr(3, 2'b11);
    exp_wr(3, 2'b11);
    res_valid = 1'b1;
    res_idx = 5'd3;
    res_taken = 1'b1;
    cyc1();
    chk("lat_rd_en", 32'(pht_rd_en), 32'd1);
    chk("lat_rd_idx", 32'(pht_rd_idx), 32'd3);
    cyc1();
    chk("lat_wr_en", 32'(pht_wr_en), 32'd1);
    cyc1();
    res_valid = 1'b0;
    wait_drain("idx3_drain");
    chk("wr_count_idx3", 32'(wr_cyc_q.size()), 32'd3);
    if (wr_cyc_q.size() == 3) begin
      chk("wr_gap_0", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd2);
      chk("wr_gap_1", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'd2);
    end
    // idx 7 not-taken twice: second read must see the fresh 00
    exp_wr(7, 2'b00);
    exp_wr(7, 2'b00);
    res_valid = 1'b1;
    res_idx = 5'd7;
    res_taken = 1'b0;
    cyc1();
    cyc1();
    res_valid = 1'b0;
    cyc1();
    chk("idx7_second_rd_en", 32'(pht_rd_en), 32'd1);
    cyc1();
    chk("idx7_second_rd_data", 32'(pht_rd_data), 32'd0);
    wait_drain("idx7_drain");
    // lookups block the read for five cycles
    exp_wr(5, 2'b10);
    lookup_valid = 1'b1;
    res_valid = 1'b1;
    res_idx = 5'd5;
    res_taken = 1'b1;
    cyc1();
    res_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("lookup_block_%0d", i), 32'(pht_rd_en), 32'd0);
      cyc1();
    end
    lookup_valid = 1'b0;
    #1;
    chk("lookup_release_rd_en", 32'(pht_rd_en), 32'd1);
    chk("lookup_release_rd_idx", 32'(pht_rd_idx), 32'd5);
    wait_drain("lookup_drain");
    // fill during init, drop three, then push while full alongside a pop
    rst = 1'b1;
    cyc1();
    exp_sweep();
    pushes = '{'{5'd1, 2'b10}, '{5'd2, 2'b00}, '{5'd9, 2'b10}, '{5'd9, 2'b11},
               '{5'd20, 2'b10}, '{5'd20, 2'b10}, '{5'd20, 2'b10}};
    for (int i = 0; i < 4; i++) exp_q.push_back(pushes[i]);
    rst = 1'b0;
    res_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      res_idx = pushes[i].idx;
      res_taken = pushes[i].data[1];
      cyc1();
    end
    res_valid = 1'b0;
    chk("fill_upd_full", 32'(upd_full), 32'd1);
    chk("fill_drop_cnt", 32'(drop_cnt), 32'd3);
    wait_init(n);
    chk("fill_init_cycles", 32'(n), 32'd25);
    chk("fill_rd_en", 32'(pht_rd_en), 32'd1);
    chk("fill_rd_idx", 32'(pht_rd_idx), 32'd1);
    cyc1();
    chk("fill_wr_en", 32'(pht_wr_en), 32'd1);
    exp_wr(12, 2'b00);
    res_valid = 1'b1;
    res_idx = 5'd12;
    res_taken = 1'b0;
    cyc1();
    res_valid = 1'b0;
    chk("push_pop_full", 32'(upd_full), 32'd1);
    chk("push_pop_drop_cnt", 32'(drop_cnt), 32'd3);
    wait_drain("fill_drain");
    // reset during RD abandons the write and restarts the sweep
    res_valid = 1'b1;
    res_idx = 5'd4;
    res_taken = 1'b1;
    cyc1();
    res_valid = 1'b0;
    chk("rstrd_rd_en", 32'(pht_rd_en), 32'd1);
    cyc1();
    rst = 1'b1;
    #1;
    chk("rstrd_no_wr", 32'(pht_wr_en), 32'd0);
    cyc1();
    exp_sweep();
    rst = 1'b0;
    chk("rstrd_upd_full", 32'(upd_full), 32'd0);
    chk("rstrd_init_done", 32'(init_done), 32'd0);
    chk("rstrd_wr_idx", 32'(pht_wr_idx), 32'd0);
    chk("rstrd_wr_en", 32'(pht_wr_en), 32'd1);
    wait_init(n);
    chk("rstrd_init_cycles", 32'(n), 32'd32);
    cyc1();
    cyc1();
    chk("rstrd_queue_empty_rd_en", 32'(pht_rd_en), 32'd0);
    chk("rstrd_exp_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
